// File: rtl/sub_float64_sigs.sv
// sub_float64_sigs: multi-cycle binary64 magnitude subtraction, round-to-nearest-even
module sub_float64_sigs (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        zSign,
    input  logic [5:0]  working_key,
    output logic [63:0] ap_return
);
    typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;
    localparam logic [63:0] HIDDEN = 64'h4000_0000_0000_0000;
    localparam logic [63:0] QUIET  = 64'h0008_0000_0000_0000;

    function automatic logic [63:0] jam(input logic [63:0] v, input logic [15:0] c);
        return (c == 16'd0) ? v :
               (c < 16'd64) ? ((v >> c) | 64'(|(v & ~({64{1'b1}} << c)))) : 64'(|v);
    endfunction

    function automatic logic [6:0] clz(input logic [63:0] v);
        clz = 7'd64;
        for (int i = 0; i < 64; i++)
            if (v[i]) clz = 7'(63 - i);
    endfunction

    state_t r_state, w_next;
    logic [63:0] r_a, r_b, r_x, r_y, r_z, r_sval;
    logic r_sign, r_zs, r_spec;
    logic signed [15:0] r_exp;
    logic w_unused;
    assign w_unused = ^working_key;

    logic [10:0] w_ae, w_be;
    logic [63:0] w_as, w_bs, w_nan;
    logic signed [11:0] w_d;
    logic [15:0] w_sh;
    logic w_an, w_bn;
    assign w_ae  = r_a[62:52];
    assign w_be  = r_b[62:52];
    assign w_as  = {2'b0, r_a[51:0], 10'd0};
    assign w_bs  = {2'b0, r_b[51:0], 10'd0};
    assign w_d   = $signed({1'b0, w_ae}) - $signed({1'b0, w_be});
    assign w_sh  = ((w_d < 0) ? 16'(-w_d) : 16'(w_d)) - 16'((w_d < 0) ? (w_ae == 11'd0) : (w_be == 11'd0));
    assign w_an  = &w_ae && |r_a[51:0];
    assign w_bn  = &w_be && |r_b[51:0];
    // signaling NaNs outrank quiet ones; b wins ties
    assign w_nan = (w_bn && !r_b[51]) ? r_b | QUIET : (w_an && !r_a[51]) ? r_a | QUIET :
                   w_bn ? r_b | QUIET : r_a | QUIET;

    logic w_spec, w_sg;
    logic [63:0] w_sval, w_x, w_y;
    logic signed [15:0] w_exp;
    always_comb begin
        w_spec = 1'b0;
        w_sval = '0;
        w_x    = w_as;
        w_y    = w_bs;
        w_exp  = 16'(w_ae);
        w_sg   = r_sign;
        if (w_d == 12'sd0) begin
            if (&w_ae) begin
                w_spec = 1'b1;
                w_sval = (|r_a[51:0] || |r_b[51:0]) ? w_nan : 64'h7FFF_FFFF_FFFF_FFFF;
            end else if (w_as == w_bs) begin
                w_spec = 1'b1;
            end else begin
                w_exp = (w_ae == 11'd0) ? 16'd1 : 16'(w_ae);
                if (w_as < w_bs) begin
                    w_x  = w_bs;
                    w_y  = w_as;
                    w_sg = ~r_sign;
                end
            end
        end else if (w_d < 0) begin
            if (&w_be) begin
                w_spec = 1'b1;
                w_sval = |r_b[51:0] ? w_nan : {~r_sign, 11'h7FF, 52'd0};
            end else begin
                w_x   = w_bs | HIDDEN;
                w_y   = jam((w_ae == 11'd0) ? w_as : w_as | HIDDEN, w_sh);
                w_exp = 16'(w_be);
                w_sg  = ~r_sign;
            end
        end else if (&w_ae) begin
            w_spec = 1'b1;
            w_sval = |r_a[51:0] ? w_nan : r_a;
        end else begin
            w_x = w_as | HIDDEN;
            w_y = jam((w_be == 11'd0) ? w_bs : w_bs | HIDDEN, w_sh);
        end
    end

    logic [6:0] w_s;
    logic [63:0] w_zn, w_inc, w_zu, w_zr, w_res;
    logic signed [15:0] w_e0, w_eu;
    logic [10:0] w_ze;
    logic w_ovf;
    always_comb begin
        w_s   = clz(r_z) - 7'd1;
        w_zn  = r_z << w_s;
        w_e0  = r_exp - 16'sd1 - $signed(16'(w_s));
        w_inc = w_zn + 64'h200;
        w_ovf = (w_e0 > 16'sd2045) || (w_e0 == 16'sd2045 && w_inc[63]);
        w_zu  = (w_e0 < 0) ? jam(w_zn, -w_e0) : w_zn;
        w_eu  = (w_e0 < 0) ? 16'sd0 : w_e0;
        w_zr  = ((w_zu + 64'h200) >> 10) & ~64'(w_zu[9:0] == 10'h200);
        w_ze  = (w_zr == 64'd0) ? 11'd0 : w_eu[10:0];
        w_res = w_ovf ? {r_zs, 11'h7FF, 52'd0} : {r_zs, 63'd0} + {1'b0, w_ze, 52'd0} + w_zr;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb
        w_next = (r_state == IDLE) ? (ap_start ? ALIGN : IDLE) : (r_state == ALIGN) ? SUB :
                 (r_state == SUB) ? NORM : (r_state == NORM) ? DONE : IDLE;

    always_comb begin
        ap_done  = r_state == DONE;
        ap_ready = r_state == DONE;
        ap_idle  = r_state == IDLE && !ap_start;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sign    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_exp     <= '0;
            r_zs      <= 1'b0;
            r_spec    <= 1'b0;
            r_sval    <= '0;
            ap_return <= '0;
        end else begin
            if (r_state == IDLE && ap_start) begin
                r_a    <= a;
                r_b    <= b;
                r_sign <= zSign;
            end
            if (r_state == ALIGN) begin
                r_x    <= w_x;
                r_y    <= w_y;
                r_exp  <= w_exp;
                r_zs   <= w_sg;
                r_spec <= w_spec;
                r_sval <= w_sval;
            end
            if (r_state == SUB) r_z <= r_x - r_y;
            if (r_state == NORM) ap_return <= r_spec ? r_sval : w_res;
        end
    end
endmodule

// File: tb/tb_sub_float64_sigs.sv
// tb_sub_float64_sigs: directed and randomized checks against a real-arithmetic reference
module tb_sub_float64_sigs;
    logic ap_clk = 1'b0, ap_rst = 1'b1, ap_start = 1'b0, zSign = 1'b0;
    logic ap_done, ap_idle, ap_ready;
    logic [63:0] a = '0, b = '0, ap_return;
    logic [5:0] working_key = '0;
    int tests = 0, fails = 0;

    always #5 ap_clk = ~ap_clk;

    sub_float64_sigs dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .a(a), .b(b), .zSign(zSign),
        .working_key(working_key), .ap_return(ap_return)
    );

    localparam logic [63:0] Q = 64'h0008_0000_0000_0000;

    // magnitude difference via host IEEE double arithmetic, specials by rule
    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y, input logic zs);
        logic xn, yn, xi, yi;
        real d;
        xn = x[62:52] == 11'h7FF && x[51:0] != 52'd0;
        yn = y[62:52] == 11'h7FF && y[51:0] != 52'd0;
        xi = x[62:0] == {11'h7FF, 52'd0};
        yi = y[62:0] == {11'h7FF, 52'd0};
        if (xn || yn) return (yn && !y[51]) ? y | Q : (xn && !x[51]) ? x | Q : yn ? y | Q : x | Q;
        if (xi && yi) return 64'h7FFF_FFFF_FFFF_FFFF;
        if (xi) return x;
        if (yi) return {~zs, 11'h7FF, 52'd0};
        if (x[62:0] == y[62:0]) return 64'd0;
        d = $bitstoreal({1'b0, x[62:0]}) - $bitstoreal({1'b0, y[62:0]});
        return $realtobits(zs ? -d : d);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [63:0] x, input logic [63:0] y, input logic zs,
                      output logic [63:0] r, output int cyc);
        @(negedge ap_clk);
        a = x;
        b = y;
        zSign = zs;
        working_key = 6'($urandom());
        ap_start = 1'b1;
        cyc = 0;
        while (!ap_done && cyc < 20) begin
            @(negedge ap_clk);
            cyc++;
        end
        chk("done", 64'(ap_done), 64'd1);
        r = ap_return;
        ap_start = 1'b0;
    endtask

    task automatic dir(input string tag, input logic [63:0] x, input logic [63:0] y,
                       input logic zs, input logic [63:0] exp);
        logic [63:0] r;
        int cyc;
        op(x, y, zs, r, cyc);
        chk(tag, r, exp);
        chk({tag, "_lat"}, 64'(cyc), 64'd4);
        chk({tag, "_ready"}, 64'(ap_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] r, x, y;
        logic zs, seen;
        int cyc;
        repeat (2) @(negedge ap_clk);
        chk("reset_done", 64'(ap_done), 64'd0);
        chk("reset_idle", 64'(ap_idle), 64'd1);
        chk("reset_ret", ap_return, 64'd0);
        ap_rst = 1'b0;
        dir("basic", 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 64'h3FF0_0000_0000_0000);
        @(negedge ap_clk);
        chk("done_width", 64'(ap_done), 64'd0);
        chk("idle_after", 64'(ap_idle), 64'd1);
        dir("sign_flip", 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 64'hBFF0_0000_0000_0000);
        dir("equal", 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 64'h0);
        dir("subnormal", 64'h2, 64'h1, 1'b0, 64'h1);
        dir("inf_inf", 64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
        dir("inf_one", 64'h7FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 64'h7FF0_0000_0000_0000);
        dir("one_inf", 64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b0, 64'hFFF0_0000_0000_0000);
        dir("snan_a", 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b0, 64'h7FF8_0000_0000_0001);
        dir("snan_b", 64'h7FF8_0000_0000_0002, 64'h7FF0_0000_0000_0003, 1'b0, 64'h7FF8_0000_0000_0003);
        @(negedge ap_clk);
        a = 64'h4008_0000_0000_0000;
        b = 64'h3FF0_0000_0000_0000;
        zSign = 1'b0;
        ap_start = 1'b1;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b1;
        ap_start = 1'b0;
        #1;
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_ret", ap_return, 64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge ap_clk);
            seen |= ap_done;
        end
        chk("rst_no_done", 64'(seen), 64'd0);
        dir("after_rst", 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0, 64'h4000_0000_0000_0000);
        for (int i = 0; i < 200; i++) begin
            x = {$urandom(), $urandom()};
            y = {$urandom(), $urandom()};
            zs = 1'($urandom());
            if (i % 4 == 1) y[62:52] = x[62:52] + 11'($urandom_range(0, 4)) - 11'd2;
            else if (i % 4 == 2) begin
                x[62:53] = '0;
                y[62:53] = '0;
            end else if (i % 4 == 3) y[62:40] = x[62:40];
            if (i % 16 == 5) x[62:52] = 11'h7FF;
            if (i % 32 == 7) y = x ^ 64'h8000_0000_0000_0000;
            op(x, y, zs, r, cyc);
            chk("rand", r, model(x, y, zs));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
